// File: rtl/send_signal.sv
// send_signal: streaming 8-point DFT over a sliding window of the newest
// 8 signed 32-bit samples. All 16 bin components are registered and
// reflect the window including the sample captured at the same edge.
module send_signal (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  output logic [31:0] Xr0,
  output logic [31:0] Xr1,
  output logic [31:0] Xr2,
  output logic [31:0] Xr3,
  output logic [31:0] Xr4,
  output logic [31:0] Xr5,
  output logic [31:0] Xr6,
  output logic [31:0] Xr7,
  output logic [31:0] Xi0,
  output logic [31:0] Xi1,
  output logic [31:0] Xi2,
  output logic [31:0] Xi3,
  output logic [31:0] Xi4,
  output logic [31:0] Xi5,
  output logic [31:0] Xi6,
  output logic [31:0] Xi7
);

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 40;
  localparam int unsigned PW = 64;
  localparam logic signed [PW-1:0] TWID_C = 64'sd46341;

  logic signed [DW-1:0] x_q [N];
  logic signed [DW-1:0] x_d [N];
  logic signed [SW-1:0] e   [N];
  logic [DW-1:0] xr_q [N];
  logic [DW-1:0] xi_q [N];
  logic [DW-1:0] xr_d [N];
  logic [DW-1:0] xi_d [N];

  // Exact part plus floor((A*C)/2^16), wrapped to the output width.
  function automatic logic [DW-1:0] odd_term(input logic signed [SW-1:0] exact,
                                             input logic signed [SW-1:0] a);
    logic signed [PW-1:0] prod;
    prod = PW'(a) * TWID_C;
    return DW'(PW'(exact) + (prod >>> 16));
  endfunction

  // Shift the window: x0 is the oldest, x7 takes the incoming sample.
  always_comb begin
    for (int i = 0; i < int'(N) - 1; i++) begin
      x_d[i] = x_q[i+1];
    end
    x_d[N-1] = $signed(data);
  end

  // DFT of the shifted window; odd-n twiddles share one scaled sum per component.
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      e[i] = SW'(x_d[i]);
    end

    xr_d[0] = DW'(e[0] + e[1] + e[2] + e[3] + e[4] + e[5] + e[6] + e[7]);
    xi_d[0] = '0;

    xr_d[4] = DW'(e[0] - e[1] + e[2] - e[3] + e[4] - e[5] + e[6] - e[7]);
    xi_d[4] = '0;

    xr_d[2] = DW'(e[0] - e[2] + e[4] - e[6]);
    xr_d[6] = DW'(e[0] - e[2] + e[4] - e[6]);
    xi_d[2] = DW'(-e[1] + e[3] - e[5] + e[7]);
    xi_d[6] = DW'(e[1] - e[3] + e[5] - e[7]);

    xr_d[1] = odd_term(e[0] - e[4], e[1] - e[3] - e[5] + e[7]);
    xr_d[7] = odd_term(e[0] - e[4], e[1] - e[3] - e[5] + e[7]);
    xi_d[1] = odd_term(e[6] - e[2], -e[1] - e[3] + e[5] + e[7]);
    xi_d[7] = odd_term(e[2] - e[6], e[1] + e[3] - e[5] - e[7]);

    xr_d[3] = odd_term(e[0] - e[4], -e[1] + e[3] + e[5] - e[7]);
    xr_d[5] = odd_term(e[0] - e[4], -e[1] + e[3] + e[5] - e[7]);
    xi_d[3] = odd_term(e[2] - e[6], -e[1] - e[3] + e[5] + e[7]);
    xi_d[5] = odd_term(e[6] - e[2], e[1] + e[3] - e[5] - e[7]);
  end

  // Window and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        x_q[i]  <= '0;
        xr_q[i] <= '0;
        xi_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        x_q[i]  <= x_d[i];
        xr_q[i] <= xr_d[i];
        xi_q[i] <= xi_d[i];
      end
    end
  end

  assign Xr0 = xr_q[0];
  assign Xr1 = xr_q[1];
  assign Xr2 = xr_q[2];
  assign Xr3 = xr_q[3];
  assign Xr4 = xr_q[4];
  assign Xr5 = xr_q[5];
  assign Xr6 = xr_q[6];
  assign Xr7 = xr_q[7];
  assign Xi0 = xi_q[0];
  assign Xi1 = xi_q[1];
  assign Xi2 = xi_q[2];
  assign Xi3 = xi_q[3];
  assign Xi4 = xi_q[4];
  assign Xi5 = xi_q[5];
  assign Xi6 = xi_q[6];
  assign Xi7 = xi_q[7];

endmodule

// File: tb/tb_send_signal.sv
// Bench for send_signal: directed vector table, random stream against a
// direct-summation DFT model, and a hand-written mid-stream reset sequence.
module tb_send_signal;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic [31:0] xr [8];
  logic [31:0] xi [8];

  int passed = 0;
  int total  = 0;

  // Model window, index 0 oldest.
  longint win [8];

  // Sign/scale of cos and -sin at angle m*pi/4: +-1 exact, +-2 means +-C.
  int cos_t  [8] = '{1, 2, 0, -2, -1, -2, 0, 2};
  int nsin_t [8] = '{0, -2, -1, -2, 0, 2, 1, 2};

  typedef struct {
    logic        rst;
    logic [31:0] data;
    bit          chk;
    logic [31:0] er0;
    logic [31:0] er1;
    logic [31:0] ei1;
    logic [31:0] ei2;
    logic [31:0] er4;
  } vec_t;

  vec_t vecs [$];

  send_signal dut (
    .clk(clk), .rst(rst), .data(data),
    .Xr0(xr[0]), .Xr1(xr[1]), .Xr2(xr[2]), .Xr3(xr[3]),
    .Xr4(xr[4]), .Xr5(xr[5]), .Xr6(xr[6]), .Xr7(xr[7]),
    .Xi0(xi[0]), .Xi1(xi[1]), .Xi2(xi[2]), .Xi3(xi[3]),
    .Xi4(xi[4]), .Xi5(xi[5]), .Xi6(xi[6]), .Xi7(xi[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint floor_div(input longint p, input longint d);
    longint q;
    q = p / d;
    if ((p % d != 0) && (p < 0)) q = q - 1;
    return q;
  endfunction

  // Direct DFT summation over the model window.
  function automatic logic [31:0] exp_bin(input int k, input bit im);
    longint exact;
    longint a;
    int     m;
    int     c;
    exact = 0;
    a     = 0;
    for (int n = 0; n < 8; n++) begin
      m = (k * n) % 8;
      c = im ? nsin_t[m] : cos_t[m];
      if (c == 1)       exact = exact + win[n];
      else if (c == -1) exact = exact - win[n];
      else if (c == 2)  a = a + win[n];
      else if (c == -2) a = a - win[n];
    end
    return 32'(exact + floor_div(a * 46341, 65536));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s Xr%0d", tag, k), xr[k], exp_bin(k, 1'b0));
      check($sformatf("%s Xi%0d", tag, k), xi[k], exp_bin(k, 1'b1));
    end
  endtask

  task automatic step(input logic r, input logic [31:0] d);
    rst  = r;
    data = d;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) win[i] = 0;
    end else begin
      for (int i = 0; i < 7; i++) win[i] = win[i+1];
      win[7] = longint'($signed(d));
    end
    #1;
  endtask

  function automatic void add(input logic r, input logic [31:0] d, input bit c,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input logic [31:0] a4);
    vec_t v;
    v.rst = r; v.data = d; v.chk = c;
    v.er0 = a0; v.er1 = a1; v.ei1 = a2; v.ei2 = a3; v.er4 = a4;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] d;
    rst  = 1'b1;
    data = 32'h0;
    for (int i = 0; i < 8; i++) win[i] = 0;

    // Reset held two edges with nonzero data.
    add(1'b1, 32'h12345678, 1'b1, 0, 0, 0, 0, 0);
    add(1'b1, 32'h12345678, 1'b1, 0, 0, 0, 0, 0);
    // DC.
    for (int i = 0; i < 8; i++) add(1'b0, 32'd100, i == 7, 32'd800, 0, 0, 0, 0);
    // Impulse from a clean window.
    add(1'b1, 32'h0, 1'b1, 0, 0, 0, 0, 0);
    add(1'b0, 32'd65536, 1'b1, 32'd65536, 32'd46341, 32'd46341, 32'd65536, -32'sd65536);
    for (int i = 0; i < 7; i++) add(1'b0, 32'h0, i == 6, 32'd65536, 32'd65536, 0, 0, 32'd65536);
    // Alternating +100/-100.
    for (int i = 0; i < 8; i++)
      add(1'b0, (i % 2 == 0) ? 32'd100 : -32'sd100, i == 7, 0, 0, 0, 0, 32'd800);
    // Overflow wrap.
    for (int i = 0; i < 8; i++) add(1'b0, 32'h7FFFFFFF, i == 7, 32'hFFFFFFF8, 0, 0, 0, 0);

    foreach (vecs[v]) begin
      step(vecs[v].rst, vecs[v].data);
      if (vecs[v].chk) begin
        check($sformatf("vec%0d Xr0", v), xr[0], vecs[v].er0);
        check($sformatf("vec%0d Xr1", v), xr[1], vecs[v].er1);
        check($sformatf("vec%0d Xi1", v), xi[1], vecs[v].ei1);
        check($sformatf("vec%0d Xi2", v), xi[2], vecs[v].ei2);
        check($sformatf("vec%0d Xr4", v), xr[4], vecs[v].er4);
      end
      check_all($sformatf("vec%0d", v));
    end

    // Random stream with occasional resets and small-magnitude samples.
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = 32'($signed($urandom_range(0, 2000)) - 1000);
      step($urandom_range(0, 31) == 0, d);
      check_all($sformatf("rnd%0d", i));
    end

    // Mid-stream reset, then a single small sample.
    step(1'b1, 32'hDEADBEEF);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("midrst Xr%0d", k), xr[k], 32'h0);
      check($sformatf("midrst Xi%0d", k), xi[k], 32'h0);
    end
    step(1'b0, 32'd8);
    check("after8 Xr0", xr[0], 32'd8);
    check("after8 Xr1", xr[1], 32'd5);
    check("after8 Xi1", xi[1], 32'd5);
    check("after8 Xi2", xi[2], 32'd8);
    check("after8 Xr4", xr[4], 32'hFFFFFFF8);
    check_all("after8");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
